// File: rtl/approx_mul_seq.sv
`timescale 1ns/1ps
// approx_mul_seq: sequential shift-add multiplier with a per-request
// exact/approximate mode. Each request runs one partial-product iteration
// per cycle and stops as soon as no multiplier bits remain.
//
// Handshake rule, both sides: a transfer happens on a rising clk edge where
// valid && ready are both high. A producer holds valid (and its data) stable
// until it sees ready. Once raised, out_valid stays high with p/cycles stable
// until its transfer.
module approx_mul_seq #(
  parameter int WIDTH = 8,
  parameter int TRUNC = 4,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               approx_en,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic [CW-1:0]      cycles,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Mask that clears the TRUNC low product columns; all ones when TRUNC is 0.
  localparam logic [2*WIDTH-1:0] ONE_P     = {{(2*WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] KEEP_MASK = ~((ONE_P << TRUNC) - ONE_P);

  state_t             state_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic               approx_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [CW-1:0]      cnt_q;
  logic               out_valid_q;
  logic [2*WIDTH-1:0] p_q;
  logic [CW-1:0]      cycles_q;

  logic [WIDTH-1:0]   b_sh;
  logic [2*WIDTH-1:0] pp;
  logic [2*WIDTH-1:0] acc_d;
  logic [CW-1:0]      cnt_d;
  logic               last_d;

  // One iteration: add the (possibly truncated) shifted multiplicand when the
  // current multiplier bit is set, and detect that no higher bits remain.
  always_comb begin
    b_sh   = b_q >> cnt_q;
    pp     = {{WIDTH{1'b0}}, a_q} << cnt_q;
    if (approx_q) begin
      pp = pp & KEEP_MASK;
    end
    acc_d  = b_sh[0] ? (acc_q + pp) : acc_q;
    cnt_d  = cnt_q + CW'(1);
    last_d = (cnt_q == CW'(WIDTH - 1)) || ((b_sh >> 1) == '0);
  end

  // Control FSM plus datapath registers; result registers load on the last
  // iteration so p/cycles are ready in the same cycle out_valid rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      approx_q    <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      p_q         <= '0;
      cycles_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q      <= a;
            b_q      <= b;
            approx_q <= approx_en;
            acc_q    <= '0;
            cnt_q    <= '0;
            state_q  <= RUN;
          end
        end
        RUN: begin
          acc_q <= acc_d;
          cnt_q <= cnt_d;
          if (last_d) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            p_q         <= acc_d;
            cycles_q    <= cnt_d;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign p         = p_q;
  assign cycles    = cycles_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_approx_mul_seq.sv
`timescale 1ns/1ps
// Bench for approx_mul_seq: directed vectors with literal expectations, a
// spec-level product/latency model, and one negedge monitor that checks the
// outputs on every cycle.
module tb_approx_mul_seq;

  localparam int W    = 8;
  localparam int T    = 4;
  localparam int CW   = $clog2(W + 1);
  localparam int NDIR = 7;

  logic           clk       = 1'b0;
  logic           rst_n     = 1'b0;
  logic           in_valid  = 1'b0;
  logic           in_ready;
  logic [W-1:0]   a         = '0;
  logic [W-1:0]   b         = '0;
  logic           approx_en = 1'b0;
  logic           out_valid;
  logic           out_ready;
  logic           man_rdy   = 1'b1;
  logic           rnd_rdy   = 1'b0;
  logic           rand_mode = 1'b0;
  logic [2*W-1:0] p;
  logic [CW-1:0]  cycles;
  logic [1:0]     dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [2*W-1:0] exp_q[$];

  // Directed vectors in result order: operands, product, cycles, latency.
  typedef struct {
    int a; int b; int ap; int p; int cyc; int lat;
  } dir_t;

  dir_t dir_tab [NDIR] = '{
    '{13,  1,   0, 13,    1, 2},
    '{200, 0,   0, 0,     1, 2},
    '{3,   128, 0, 384,   8, 9},
    '{255, 255, 0, 65025, 8, 9},
    '{255, 255, 1, 64976, 8, 9},
    '{100, 5,   0, 500,   3, 4},
    '{7,   9,   0, 63,    4, 5}
  };

  assign out_ready = rand_mode ? rnd_rdy : man_rdy;

  approx_mul_seq #(.WIDTH(W), .TRUNC(T)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .approx_en (approx_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p),
    .cycles    (cycles),
    .dbg_state (dbg_state)
  );

  // Clock and random consumer backpressure.
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    rnd_rdy = ($urandom_range(0, 3) != 0);
  end

  // Iterations needed: position of highest set multiplier bit, at least 1.
  function automatic int kfun(input logic [W-1:0] bv);
    int k;
    k = 1;
    for (int i = 0; i < W; i++) begin
      if (bv[i]) k = i + 1;
    end
    return k;
  endfunction

  // Product as the sum of shifted multiplicands, each with its low T columns
  // dropped in approximate mode; exact mode is plain multiplication.
  function automatic logic [2*W-1:0] model_p(input logic [W-1:0] av,
                                              input logic [W-1:0] bv,
                                              input logic apv);
    logic [2*W-1:0] s;
    logic [2*W-1:0] term;
    if (!apv) begin
      s = (2*W)'(av) * (2*W)'(bv);
    end else begin
      s = '0;
      for (int i = 0; i < W; i++) begin
        if (bv[i]) begin
          term = (2*W)'(av) << i;
          term = (term >> T) << T;
          s = s + term;
        end
      end
    end
    return s;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor / scoreboard: the only process that compares.
  initial begin : monitor
    bit             busy;
    bit             seen;
    int             cnt;
    int             res_idx;
    int             exp_k;
    logic [W-1:0]   ca;
    logic [W-1:0]   cb;
    logic           cap;
    logic [63:0]    prod;
    logic [2*W-1:0] lowmask;
    busy    = 1'b0;
    seen    = 1'b0;
    cnt     = 0;
    res_idx = 0;
    exp_k   = 1;
    ca      = '0;
    cb      = '0;
    cap     = 1'b0;
    lowmask = (2*W)'((1 << T) - 1);

    chk("pin_model_approx", 64'(model_p(8'd255, 8'd255, 1'b1)), 64'd64976);
    chk("pin_model_exact",  64'(model_p(8'd3, 8'h80, 1'b0)),    64'd384);
    chk("pin_model_small",  64'(model_p(8'd13, 8'd1, 1'b1)),    64'd0);
    chk("pin_k_zero",       64'(kfun(8'd0)),                    64'd1);
    chk("pin_k_msb",        64'(kfun(8'h80)),                   64'd8);

    forever begin
      @(negedge clk or negedge rst_n);
      if (!rst_n) begin
        #1;
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_p",         64'(p),         64'd0);
        chk("rst_cycles",    64'(cycles),    64'd0);
        chk("rst_state",     64'(dbg_state), 64'd0);
        busy = 1'b0;
        seen = 1'b0;
        exp_q.delete();
      end else begin
        chk("in_ready", 64'(in_ready), 64'(!busy));
        if (!busy) begin
          chk("idle_out_valid", 64'(out_valid), 64'd0);
          if (in_valid && in_ready) begin
            busy  = 1'b1;
            seen  = 1'b0;
            cnt   = 0;
            ca    = a;
            cb    = b;
            cap   = approx_en;
            exp_k = kfun(b);
            exp_q.push_back(model_p(a, b, approx_en));
          end
        end else begin
          cnt++;
          if (!seen) begin
            if (out_valid) begin
              seen = 1'b1;
              prod = 64'(ca) * 64'(cb);
              chk("latency", 64'(cnt),    64'(exp_k + 1));
              chk("p",       64'(p),      64'(exp_q[0]));
              chk("cycles",  64'(cycles), 64'(exp_k));
              if (cap) begin
                chk("approx_low_zero", 64'(p & lowmask), 64'd0);
                chk("approx_le_exact", 64'(64'(p) <= prod), 64'd1);
              end else begin
                chk("exact_product", 64'(p), prod);
              end
              if (res_idx < NDIR) begin
                chk("dir_p",       64'(p),      64'(dir_tab[res_idx].p));
                chk("dir_cycles",  64'(cycles), 64'(dir_tab[res_idx].cyc));
                chk("dir_latency", 64'(cnt),    64'(dir_tab[res_idx].lat));
              end
            end else if (cnt > W + 4) begin
              chk("result_timeout", 64'(cnt), 64'(exp_k + 1));
              busy = 1'b0;
              void'(exp_q.pop_front());
            end
          end else begin
            chk("hold_valid",  64'(out_valid), 64'd1);
            chk("hold_p",      64'(p),         64'(exp_q[0]));
            chk("hold_cycles", 64'(cycles),    64'(exp_k));
          end
          if (busy && seen && out_valid && out_ready) begin
            busy = 1'b0;
            void'(exp_q.pop_front());
            res_idx++;
          end
        end
      end
    end
  end

  // Present operands, hold until accepted, then scramble the bus.
  task automatic issue(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic api);
    int n;
    n = 0;
    @(posedge clk);
    #1;
    a = ai;
    b = bi;
    approx_en = api;
    in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    approx_en = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 50);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(out_valid && out_ready) && n < 200);
    @(posedge clk);
    #1;
  endtask

  // Driver: directed sequence, then the random sweep, then the report.
  initial begin : driver
    int n;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (10) @(posedge clk);

    issue(8'd13, 8'd1, 1'b0);
    wait_done();

    // Asynchronous reset between edges while idle with a stale result.
    @(posedge clk);
    #2 rst_n = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;

    issue(8'd200, 8'd0, 1'b0);   wait_done();
    issue(8'd3, 8'h80, 1'b0);    wait_done();
    issue(8'd255, 8'd255, 1'b0); wait_done();
    issue(8'd255, 8'd255, 1'b1); wait_done();

    // Backpressure: result held while inputs wiggle.
    man_rdy = 1'b0;
    issue(8'd100, 8'd5, 1'b0);
    wait_valid();
    repeat (5) begin
      @(posedge clk);
      #1;
      a = W'($urandom);
      b = W'($urandom);
      in_valid = ~in_valid;
    end
    @(posedge clk);
    #1;
    a = 8'd7;
    b = 8'd9;
    approx_en = 1'b0;
    in_valid = 1'b1;
    man_rdy = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 50);
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_done();

    // Reset in the middle of a full-length run.
    issue(8'd255, 8'd255, 1'b0);
    repeat (3) @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (12) @(posedge clk);

    // Random sweep with random consumer backpressure.
    rand_mode = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      issue(W'($urandom_range(0, 255)),
            W'($urandom_range(0, 255) >> $urandom_range(0, 8)),
            1'($urandom_range(0, 1)));
    end
    wait_done();
    rand_mode = 1'b0;
    repeat (5) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
